// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the video/CPU RAM arbiter.
// Tag encoding follows each RAM issue through the two-stage pipeline.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VID  = 2'd1,
        REQ_CPU  = 2'd2
    } req_tag_e;

    localparam int RAM_ARB_MAXRUN = 4;
    localparam int STARVE_W       = 4;

endpackage

// File: rtl/ram_arb_starve.sv
// Counts video grants taken while the CPU waits; flags the CPU's turn.
// Only instantiated when RAM_ARB_FAIR_EN is defined.
module ram_arb_starve
    import ram_arb_pkg::*;
#(
    parameter int MAXRUN = RAM_ARB_MAXRUN
) (
    input  logic clock,
    input  logic reset,
    input  logic vid_gnt,
    input  logic cpu_gnt,
    input  logic cpu_elig,
    output logic cpu_turn
);

    logic [STARVE_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (cpu_gnt) begin
            count <= '0;
        end else if (vid_gnt && cpu_elig) begin
            count <= count + 1'b1;
        end
    end

    assign cpu_turn = cpu_elig && (count == STARVE_W'(MAXRUN));

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: video reads beat CPU, one issue per clock.
// Define RAM_ARB_FAIR_EN to bound consecutive video wins with MAXRUN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int  KB     = 64,
    parameter int  MAXRUN = RAM_ARB_MAXRUN,
    localparam int AW     = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [7:0]    vid_q,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_d,
    output logic          cpu_ack,
    output logic          cpu_valid,
    output logic [7:0]    cpu_q,
    output logic          cpu_wait,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    output logic          ram_w,
    input  logic [7:0]    ram_q
);

    if (MAXRUN < 1 || MAXRUN > 15) begin : g_bad_maxrun
        $error("MAXRUN must be within 1..15");
    end

    req_tag_e tag1;
    req_tag_e tag2;
    req_tag_e gnt;
    logic     vid_elig;
    logic     cpu_elig;
    logic     cpu_turn;

    // A requester acked this cycle still shows req; it must not be regranted.
    assign vid_elig = vid_req && (tag1 != REQ_VID);
    assign cpu_elig = cpu_req && (tag1 != REQ_CPU);

`ifdef RAM_ARB_FAIR_EN
    ram_arb_starve #(
        .MAXRUN(MAXRUN)
    ) u_starve (
        .clock   (clock),
        .reset   (reset),
        .vid_gnt (gnt == REQ_VID),
        .cpu_gnt (gnt == REQ_CPU),
        .cpu_elig(cpu_elig),
        .cpu_turn(cpu_turn)
    );
`else
    assign cpu_turn = 1'b0;
`endif

    always_comb begin
        gnt = REQ_NONE;
        if (cpu_elig && (cpu_turn || !vid_elig)) begin
            gnt = REQ_CPU;
        end else if (vid_elig) begin
            gnt = REQ_VID;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag1  <= REQ_NONE;
            tag2  <= REQ_NONE;
            ram_a <= '0;
            ram_d <= '0;
            ram_w <= 1'b0;
        end else begin
            tag1  <= gnt;
            tag2  <= tag1;
            ram_w <= (gnt == REQ_CPU) && cpu_we;
            unique case (gnt)
                REQ_VID: ram_a <= vid_a;
                REQ_CPU: begin
                    ram_a <= cpu_a;
                    ram_d <= cpu_d;
                end
                default: ;
            endcase
        end
    end

    assign vid_ack   = (tag1 == REQ_VID);
    assign cpu_ack   = (tag1 == REQ_CPU);
    assign vid_valid = (tag2 == REQ_VID);
    assign cpu_valid = (tag2 == REQ_CPU);

    // Write-through RAM returns the written byte, so writes need no bypass.
    assign vid_q    = ram_q;
    assign cpu_q    = ram_q;
    assign cpu_wait = cpu_req && !cpu_valid;

endmodule
